// File: rtl/ctrl_pipe_if.sv
// Purpose: bundles the ID-stage control inputs and the EX/MEM/WB control outputs of ctrl_pipe.
// Latency: wiring only, no state.
// Backpressure: none; stall is an advisory output to the fetch/decode side.
// Ports: id_* decoded controls and source/destination registers, flush, stall, fwda/fwdb,
//        e_*/m_*/w_* stage control outputs. master = decode side, slave = ctrl_pipe.
interface ctrl_pipe_if #(
  parameter int AW = 5
);
  logic          id_valid;
  logic          id_wreg;
  logic          id_m2reg;
  logic          id_wmem;
  logic          id_aluimm;
  logic [3:0]    id_aluc;
  logic [AW-1:0] id_rd;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rt;
  logic          flush;

  logic          stall;
  logic [1:0]    fwda;
  logic [1:0]    fwdb;

  logic          e_wreg;
  logic          e_m2reg;
  logic          e_wmem;
  logic          e_aluimm;
  logic [3:0]    e_aluc;
  logic [AW-1:0] e_rd;

  logic          m_wreg;
  logic          m_m2reg;
  logic          m_wmem;
  logic [AW-1:0] m_rd;

  logic          w_wreg;
  logic          w_m2reg;
  logic [AW-1:0] w_rd;

  modport master (
    output id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_aluc,
           id_rd, id_rs, id_rt, id_use_rt, flush,
    input  stall, fwda, fwdb,
           e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_rd,
           m_wreg, m_m2reg, m_wmem, m_rd,
           w_wreg, w_m2reg, w_rd
  );

  modport slave (
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_aluc,
           id_rd, id_rs, id_rt, id_use_rt, flush,
    output stall, fwda, fwdb,
           e_wreg, e_m2reg, e_wmem, e_aluimm, e_aluc, e_rd,
           m_wreg, m_m2reg, m_wmem, m_rd,
           w_wreg, w_m2reg, w_rd
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Purpose: carries decoded controls ID->EX->MEM->WB and resolves RAW hazards for the ID instruction.
// Latency: ID->EX 1 cycle, ->MEM 2, ->WB 3; stall/fwda/fwdb are combinational.
// Backpressure: none downstream; stall freezes PC/IF-ID and makes EX load a bubble.
// Ports: clk, rst (synchronous, active-high); bus (ctrl_pipe_if.slave) carries all ID inputs,
//        flush, stall, forwarding selects and the e_/m_/w_ stage controls.
// Build option: define CTRL_PIPE_FORWARD_EN for EX/MEM forwarding with load-use stalls only;
//        without it fwda/fwdb are 0 and any EX or MEM producer of a used source stalls.
module ctrl_pipe #(
  parameter int AW = 5
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic          aluimm;
    logic [3:0]    aluc;
    logic [AW-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [AW-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic [AW-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  ex_q;
  ex_ctrl_t  ex_d;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;

  logic       ex_rs_hit;
  logic       ex_rt_hit;
  logic       mem_rs_hit;
  logic       mem_rt_hit;
  logic       stall;
  logic       ex_load;
  logic [1:0] fwda;
  logic [1:0] fwdb;

  // A stage hits a source when it will write that register; r0 is never a dependence.
  // rt hits are masked by id_use_rt so the I-type rt field (a destination) never stalls or forwards.
  assign ex_rs_hit  = ex_q.wreg && (ex_q.rd == bus.id_rs) && (bus.id_rs != '0);
  assign ex_rt_hit  = bus.id_use_rt && ex_q.wreg && (ex_q.rd == bus.id_rt) && (bus.id_rt != '0);
  assign mem_rs_hit = mem_q.wreg && (mem_q.rd == bus.id_rs) && (bus.id_rs != '0);
  assign mem_rt_hit = bus.id_use_rt && mem_q.wreg && (mem_q.rd == bus.id_rt) && (bus.id_rt != '0);

`ifdef CTRL_PIPE_FORWARD_EN
  // EX wins over MEM since it holds the younger value. A load in EX has no data yet, so the
  // select falls through to MEM; the stall keeps that select from being consumed.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic e_ld, input logic m_ld);
    if (ex_hit && !e_ld) begin
      fwd_sel = 2'd1;
    end else if (mem_hit) begin
      fwd_sel = m_ld ? 2'd3 : 2'd2;
    end else begin
      fwd_sel = 2'd0;
    end
  endfunction

  always_comb begin
    stall = bus.id_valid && ex_q.m2reg && (ex_rs_hit || ex_rt_hit);
    fwda  = fwd_sel(ex_rs_hit, mem_rs_hit, ex_q.m2reg, mem_q.m2reg);
    fwdb  = fwd_sel(ex_rt_hit, mem_rt_hit, ex_q.m2reg, mem_q.m2reg);
  end
`else
  // Without bypass paths the consumer waits until the producer reaches WB, where the
  // write-first/read-second register file supplies the value.
  always_comb begin
    stall = bus.id_valid && (ex_rs_hit || ex_rt_hit || mem_rs_hit || mem_rt_hit);
    fwda  = 2'd0;
    fwdb  = 2'd0;
  end
`endif

  // flush does not mask stall; it only forces the bubble.
  assign ex_load = bus.id_valid && !stall && !bus.flush;

  always_comb begin
    ex_d = '0;
    if (ex_load) begin
      ex_d.wreg   = bus.id_wreg;
      ex_d.m2reg  = bus.id_m2reg;
      ex_d.wmem   = bus.id_wmem;
      ex_d.aluimm = bus.id_aluimm;
      ex_d.aluc   = bus.id_aluc;
      ex_d.rd     = bus.id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q.wreg  <= ex_q.wreg;
      mem_q.m2reg <= ex_q.m2reg;
      mem_q.wmem  <= ex_q.wmem;
      mem_q.rd    <= ex_q.rd;
      wb_q.wreg   <= mem_q.wreg;
      wb_q.m2reg  <= mem_q.m2reg;
      wb_q.rd     <= mem_q.rd;
    end
  end

  assign bus.stall    = stall;
  assign bus.fwda     = fwda;
  assign bus.fwdb     = fwdb;
  assign bus.e_wreg   = ex_q.wreg;
  assign bus.e_m2reg  = ex_q.m2reg;
  assign bus.e_wmem   = ex_q.wmem;
  assign bus.e_aluimm = ex_q.aluimm;
  assign bus.e_aluc   = ex_q.aluc;
  assign bus.e_rd     = ex_q.rd;
  assign bus.m_wreg   = mem_q.wreg;
  assign bus.m_m2reg  = mem_q.m2reg;
  assign bus.m_wmem   = mem_q.wmem;
  assign bus.m_rd     = mem_q.rd;
  assign bus.w_wreg   = wb_q.wreg;
  assign bus.w_m2reg  = wb_q.m2reg;
  assign bus.w_rd     = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Purpose: self-checking bench for ctrl_pipe: directed hazard tables plus random traffic vs a model.
// Latency: expects ID->EX 1, ->MEM 2, ->WB 3 cycles; combinational stall/fwd sampled at negedge.
// Backpressure: the bench ignores stall when choosing ID inputs; the model decides what issues.
module tb_ctrl_pipe;
  localparam int AW = 5;
`ifdef CTRL_PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.AW(AW)) bus();
  ctrl_pipe #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic [3:0] aluc;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
  } instr_t;

  typedef struct {
    instr_t     in;
    logic       fl;
    logic       rs;
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ew;
    logic       em;
    logic       z;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: the three instructions in flight, youngest first (EX, MEM, WB).
  instr_t     pipe [3];
  logic       x_stall;
  logic [1:0] x_fa;
  logic [1:0] x_fb;

  function automatic instr_t mk(logic v, logic w, logic m, logic wm, logic ai, logic [3:0] c,
                                logic [4:0] d, logic [4:0] s, logic [4:0] t, logic u);
    instr_t i;
    i.valid = v; i.wreg = w; i.m2reg = m; i.wmem = wm; i.aluimm = ai; i.aluc = c;
    i.rd = d; i.rs = s; i.rt = t; i.use_rt = u;
    return i;
  endfunction

  function automatic instr_t rtype(logic [3:0] c, logic [4:0] d, logic [4:0] s, logic [4:0] t);
    return mk(1, 1, 0, 0, 0, c, d, s, t, 1);
  endfunction

  function automatic instr_t lw(logic [4:0] d, logic [4:0] base);
    return mk(1, 1, 1, 0, 1, 4'h2, d, base, d, 0);
  endfunction

  function automatic instr_t sw(logic [4:0] src, logic [4:0] base);
    return mk(1, 0, 0, 1, 1, 4'h2, 5'd0, base, src, 1);
  endfunction

  function automatic vec_t v(instr_t in, logic fl, logic r, logic st, logic [1:0] fa,
                             logic [1:0] fb, logic ew, logic em, logic z);
    vec_t x;
    x.in = in; x.fl = fl; x.rs = r; x.st = st; x.fa = fa; x.fb = fb;
    x.ew = ew; x.em = em; x.z = z;
    return x;
  endfunction

  function automatic bit writes(int k, logic [4:0] r);
    return pipe[k].wreg && (pipe[k].rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] src_sel(logic [4:0] r);
    if (writes(0, r) && !pipe[0].m2reg) return 2'd1;
    if (writes(1, r)) return pipe[1].m2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic model_eval(input instr_t in);
    bit rt_used;
    bit need;
    rt_used = in.use_rt;
    if (FWD) begin
      x_fa    = src_sel(in.rs);
      x_fb    = rt_used ? src_sel(in.rt) : 2'd0;
      x_stall = in.valid && pipe[0].m2reg && (writes(0, in.rs) || (rt_used && writes(0, in.rt)));
    end else begin
      need = 1'b0;
      for (int k = 0; k < 2; k++)
        if (writes(k, in.rs) || (rt_used && writes(k, in.rt))) need = 1'b1;
      x_fa    = 2'd0;
      x_fb    = 2'd0;
      x_stall = in.valid && need;
    end
  endtask

  task automatic model_update(input instr_t in, input logic fl, input logic r);
    if (r) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (in.valid && !x_stall && !fl) ? in : '0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input instr_t in, input logic fl, input logic r);
    bus.id_valid  = in.valid;
    bus.id_wreg   = in.wreg;
    bus.id_m2reg  = in.m2reg;
    bus.id_wmem   = in.wmem;
    bus.id_aluimm = in.aluimm;
    bus.id_aluc   = in.aluc;
    bus.id_rd     = in.rd;
    bus.id_rs     = in.rs;
    bus.id_rt     = in.rt;
    bus.id_use_rt = in.use_rt;
    bus.flush     = fl;
    rst           = r;
  endtask

  // Apply inputs, sample at negedge, compare everything against the model.
  task automatic step(input instr_t in, input logic fl, input logic r);
    drive(in, fl, r);
    @(negedge clk);
    model_eval(in);
    chk("m_stall", {31'd0, bus.stall}, {31'd0, x_stall});
    chk("m_fwda", {30'd0, bus.fwda}, {30'd0, x_fa});
    chk("m_fwdb", {30'd0, bus.fwdb}, {30'd0, x_fb});
    chk("m_ex", {18'd0, bus.e_wreg, bus.e_m2reg, bus.e_wmem, bus.e_aluimm, bus.e_aluc, bus.e_rd},
        {18'd0, pipe[0].wreg, pipe[0].m2reg, pipe[0].wmem, pipe[0].aluimm, pipe[0].aluc, pipe[0].rd});
    chk("m_mem", {24'd0, bus.m_wreg, bus.m_m2reg, bus.m_wmem, bus.m_rd},
        {24'd0, pipe[1].wreg, pipe[1].m2reg, pipe[1].wmem, pipe[1].rd});
    chk("m_wb", {25'd0, bus.w_wreg, bus.w_m2reg, bus.w_rd},
        {25'd0, pipe[2].wreg, pipe[2].m2reg, pipe[2].rd});
  endtask

  task automatic advance(input instr_t in, input logic fl, input logic r);
    @(posedge clk);
    model_update(in, fl, r);
    cyc++;
    #1;
  endtask

  vec_t   tbl [$];
  instr_t nop;

  initial begin
    nop = '0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    drive(nop, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;

`ifdef CTRL_PIPE_FORWARD_EN
    //                in                          fl r  st fa fb ew em z
    tbl.push_back(v(rtype(4'h2, 3, 1, 2),         0, 0, 0, 0, 0, 0, 0, 1)); // reset state
    tbl.push_back(v(lw(2, 4),                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h2, 5, 2, 3),         0, 1, 1, 0, 2, 1, 0, 0)); // LW r2 in EX, ADD r3 in MEM, rst
    tbl.push_back(v(rtype(4'h2, 5, 2, 3),         0, 0, 0, 0, 0, 0, 0, 1)); // all cleared
    tbl.push_back(v(rtype(4'h2, 3, 1, 2),         0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h6, 4, 3, 3),         0, 0, 0, 1, 1, 1, 0, 0)); // EX ALU forward
    tbl.push_back(v(rtype(4'h5, 7, 3, 1),         0, 0, 0, 2, 0, 1, 0, 0)); // MEM ALU forward
    tbl.push_back(v(lw(5, 1),                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h2, 6, 5, 0),         0, 0, 1, 0, 0, 1, 0, 0)); // load-use stall
    tbl.push_back(v(rtype(4'h2, 6, 5, 0),         0, 0, 0, 3, 0, 0, 0, 0)); // bubble, load data
    tbl.push_back(v(rtype(4'h2, 0, 1, 2),         0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h4, 7, 0, 0),         0, 0, 0, 0, 0, 1, 0, 0)); // r0 never forwards
    tbl.push_back(v(lw(8, 1),                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(mk(1,1,1,0,1,4'h2,9,8,8,0),   0, 0, 1, 0, 0, 1, 0, 0)); // rs=r8 stalls, rt unused
    tbl.push_back(v(mk(1,1,1,0,1,4'h2,9,8,8,0),   0, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(v(rtype(4'h2, 3, 1, 2),         0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h5, 3, 1, 1),         0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h3, 9, 3, 3),         0, 0, 0, 1, 1, 1, 0, 0)); // EX over MEM
    tbl.push_back(v(sw(9, 3),                     1, 0, 0, 2, 1, 1, 0, 0)); // flush SW
    tbl.push_back(v(nop,                          0, 0, 0, 0, 0, 0, 0, 0)); // no e_wmem
    tbl.push_back(v(lw(10, 1),                    0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(rtype(4'h2, 11, 10, 10),      1, 0, 1, 0, 0, 1, 0, 0)); // flush does not mask stall
    tbl.push_back(v(nop,                          0, 0, 0, 0, 0, 0, 0, 0));
`else
    //                in                          fl r  st fa fb ew em z
    tbl.push_back(v(rtype(4'h2, 3, 1, 2),         0, 0, 0, 0, 0, 0, 0, 1)); // reset state
    tbl.push_back(v(rtype(4'h6, 4, 3, 1),         0, 0, 1, 0, 0, 1, 0, 0)); // producer in EX
    tbl.push_back(v(rtype(4'h6, 4, 3, 1),         0, 0, 1, 0, 0, 0, 0, 0)); // producer in MEM
    tbl.push_back(v(rtype(4'h6, 4, 3, 1),         0, 0, 0, 0, 0, 0, 0, 0)); // producer in WB
    tbl.push_back(v(rtype(4'h2, 5, 1, 2),         0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(nop,                          0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h5, 6, 5, 0),         0, 0, 1, 0, 0, 0, 0, 0)); // two back: 1 bubble
    tbl.push_back(v(rtype(4'h5, 6, 5, 0),         0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(lw(2, 4),                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h2, 5, 2, 2),         0, 1, 1, 0, 0, 1, 0, 0)); // rst mid-flight
    tbl.push_back(v(rtype(4'h2, 5, 2, 2),         0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(rtype(4'h2, 0, 1, 2),         0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(rtype(4'h4, 7, 0, 0),         0, 0, 0, 0, 0, 1, 0, 0)); // r0 never stalls
    tbl.push_back(v(lw(8, 1),                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(mk(1,1,1,0,1,4'h2,9,8,8,0),   0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(v(mk(1,1,1,0,1,4'h2,9,8,8,0),   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(mk(1,1,1,0,1,4'h2,9,8,8,0),   0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(sw(9, 3),                     1, 0, 1, 0, 0, 1, 0, 0)); // flush does not mask stall
    tbl.push_back(v(sw(9, 3),                     0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(sw(9, 3),                     1, 0, 0, 0, 0, 0, 0, 0)); // flush SW
    tbl.push_back(v(nop,                          0, 0, 0, 0, 0, 0, 0, 0)); // no e_wmem
`endif

    foreach (tbl[i]) begin
      step(tbl[i].in, tbl[i].fl, tbl[i].rs);
      chk($sformatf("t%0d_stall", i), {31'd0, bus.stall}, {31'd0, tbl[i].st});
      chk($sformatf("t%0d_fwda", i), {30'd0, bus.fwda}, {30'd0, tbl[i].fa});
      chk($sformatf("t%0d_fwdb", i), {30'd0, bus.fwdb}, {30'd0, tbl[i].fb});
      chk($sformatf("t%0d_e_wreg", i), {31'd0, bus.e_wreg}, {31'd0, tbl[i].ew});
      chk($sformatf("t%0d_e_wmem", i), {31'd0, bus.e_wmem}, {31'd0, tbl[i].em});
      if (tbl[i].z)
        chk($sformatf("t%0d_zero", i),
            {bus.e_wreg, bus.e_m2reg, bus.e_wmem, bus.e_aluimm, bus.e_aluc, bus.e_rd,
             bus.m_wreg, bus.m_m2reg, bus.m_wmem, bus.m_rd, bus.w_wreg, bus.w_m2reg, bus.w_rd},
            32'd0);
      advance(tbl[i].in, tbl[i].fl, tbl[i].rs);
    end

    // Random traffic over a small register window so hazards are frequent.
    for (int n = 0; n < 1500; n++) begin
      instr_t in;
      logic   fl;
      logic   r;
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 5));
      b = 5'($urandom_range(0, 5));
      c = 5'($urandom_range(0, 5));
      case ($urandom_range(0, 4))
        0:       in = mk(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         4'($urandom), a, b, c, 1'($urandom));
        1:       in = rtype(4'($urandom), a, b, c);
        2:       in = lw(a, b);
        3:       in = sw(a, b);
        default: in = mk(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         4'($urandom), a, b, c, 1'($urandom));
      endcase
      fl = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 49) == 0);
      step(in, fl, r);
      advance(in, fl, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control word from the instruction-decode stage through the EX, MEM and WB pipeline registers of the five-stage MIPS datapath. It also detects data hazards for the instruction currently in ID and resolves them with a stall and forwarding selects. It sits between the control unit / register-file read in ID and the ALU, data-memory and write-back muxes downstream.

## Interface
- Parameters:
  - `AW`, default 5: register-address width.
- Ports (synchronous reset, active-high; single clock):
  - `clk` in 1: rising-edge clock.
  - `rst` in 1: synchronous active-high reset.
  - `id_valid` in 1: ID holds a real instruction.
  - `id_wreg`, `id_m2reg`, `id_wmem`, `id_aluimm` in 1 each: decoded controls.
  - `id_aluc` in 4: ALU control.
  - `id_rd` in AW: destination register, already selected between rd and rt.
  - `id_rs`, `id_rt` in AW: source registers.
  - `id_use_rt` in 1: rt is a read source (R-type, SW).
  - `flush` in 1: turn the instruction entering EX into a bubble.
  - `stall` out 1: combinational. Freezes PC and IF/ID; EX loads a bubble.
  - `fwda`, `fwdb` out 2: combinational operand selects for ID. 0 = regfile, 1 = EX ALU result, 2 = MEM ALU result, 3 = MEM load data.
  - `e_wreg`, `e_m2reg`, `e_wmem`, `e_aluimm` out 1; `e_aluc` out 4; `e_rd` out AW: EX stage controls.
  - `m_wreg`, `m_m2reg`, `m_wmem` out 1; `m_rd` out AW: MEM stage controls.
  - `w_wreg`, `w_m2reg` out 1; `w_rd` out AW: WB stage controls.

## Operation
- Pipeline registers advance every cycle; there is no back-pressure downstream of ID.
- **EX load.** EX loads the ID controls when `id_valid & ~stall & ~flush`. Otherwise EX loads a bubble: all enables 0, `aluc` = 0, `rd` = 0.
- **Later stages.** MEM loads from EX and WB loads from MEM unconditionally.
- **Writer test.** A stage X "writes r" when `X_wreg & (X_rd == r) & (r != 0)`. Register 0 never causes a hazard or a forward.
- **Forwarding** (for each source; `fwdb` and the rt term of `stall` apply only when `id_use_rt`):
  - EX writes the source and `e_m2reg` = 0 → select 1.
  - Else if MEM writes the source → select 3 when `m_m2reg`, otherwise 2.
  - Else → select 0.
  - EX has priority over MEM.
- **Load-use stall.** `stall` = `id_valid` & EX writes a used source & `e_m2reg`.
- **WB hazards.** WB-stage hazards are not handled here. The register file writes in the first half-cycle and reads in the second.
- **Flush and stall together.** When both are asserted, EX gets a bubble. `stall` is still reported, because `flush` does not mask it.

## Timing
- **Reset.** `rst` high at a clock edge clears every stage register to 0: all enables, `aluc`, and `rd`. Consequently `stall` = 0 and `fwda` = `fwdb` = 0 in the following cycle, whatever the ID inputs are.
- **Reset mid-operation** discards all in-flight instructions.
- **Latency.** ID→EX is 1 cycle, ID→MEM 2 cycles, ID→WB 3 cycles.
- **Stall duration.** A load-use stall lasts exactly 1 cycle. The bubble moves the load into MEM, after which the select is 3.
- **Output behaviour.** `stall`, `fwda` and `fwdb` are pure functions of the current stage registers and the ID inputs, with no registered delay.

## Configuration
- **`CTRL_PIPE_FORWARD_EN` defined:** behaviour exactly as above.
- **Not defined:**
  - `fwda` and `fwdb` are tied to 0.
  - `stall` = `id_valid` & (EX writes a used source | MEM writes a used source), regardless of `m2reg`.
  - A RAW dependence on the immediately preceding ALU op therefore costs 2 bubbles, and a dependence two instructions back costs 1 bubble.

## Test plan
- **Reset mid-flight.** LW r2 in EX and ADD r3 in MEM, then assert `rst` for 1 cycle. Next cycle all `e_`/`m_`/`w_` outputs are 0, `stall` = 0, `fwda` = `fwdb` = 0.
- **ALU forwarding.** ADD r3,r1,r2 followed by SUB r4,r3,r3 (`id_use_rt` = 1). With FORWARD_EN: `fwda` = `fwdb` = 1 and `stall` = 0. The following instruction reading r3 sees select 2.
- **Load-use.** LW r5,0(r1) followed by ADD r6,r5,r0. `stall` = 1 for one cycle and `e_wreg` = 0 in the bubble cycle. Next cycle `stall` = 0 and `fwda` = 3.
- **Register zero / unused rt.**
  - ADD r0,r1,r2 followed by AND r7,r0,r0: `fwda` = `fwdb` = 0, `stall` = 0.
  - LW r8 followed by LW r9,0(r8) with `id_use_rt` = 0 and `id_rt` = 8: `stall` asserts because rs = r8. `fwdb` stays 0.
- **EX priority.** ADD r3, then OR r3, then XOR r9,r3,r3: `fwda` = 1, not 2.
- **Forwarding disabled.** Build without `CTRL_PIPE_FORWARD_EN` and run ADD r3 followed by SUB r4,r3,r1. `stall` = 1 for 2 consecutive cycles, and `fwda` = 0 throughout.
- **Flush.** Assert `flush` while SW is in ID: `e_wmem` = 0 on the next cycle.
